// File: rtl/pc_fetch_seq_pkg.sv
// Shared fetch-path definitions: datapath width, reset vector, PC step and
// the fetch sequencer state encoding. Also used by the PC register and decode.
package pc_fetch_seq_pkg;

    localparam int                WIDTH    = 16;
    localparam logic [WIDTH-1:0]  RESET_PC = 16'h0000;
    localparam logic [WIDTH-1:0]  PC_INC   = 16'h0001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        FULL   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC: redirect target, sequential step, or hold.
// The step wraps naturally at the datapath width.
module pc_next_mux
    import pc_fetch_seq_pkg::*;
(
    input  logic             redirect_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic [WIDTH-1:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i)
            pc_next_o = redirect_pc_i;
        else if (inc_i)
            pc_next_o = pc_i + PC_INC;
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: drives instruction-memory reads at the current PC, buffers
// one returned instruction for decode and decides hold/advance/redirect of PC.
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
(
    input  logic             clk,
    input  logic             PC_rst_n,
    input  logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_next,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_data,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [WIDTH-1:0] instr_data_q, instr_data_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [WIDTH-1:0] mux_pc_next;

    pc_next_mux u_pc_next_mux (
        .redirect_i    (redirect),
        .inc_i         ((state_q == FETCH) && imem_ack),
        .pc_i          (PC),
        .redirect_pc_i (redirect_pc),
        .pc_next_o     (mux_pc_next)
    );

    // Reset forces the reset vector without waiting for an edge, so the PC
    // register sees RESET_PC on every edge while reset is held.
    assign PC_next = PC_rst_n ? mux_pc_next : RESET_PC;

    always_comb begin
        state_d      = state_q;
        imem_addr_d  = imem_addr_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        imem_req     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d     = FETCH;
                imem_addr_d = PC_next;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack && !redirect) begin
                    state_d      = FULL;
                    instr_data_d = imem_rdata;
                    instr_pc_d   = imem_addr_q;
                end else if (imem_ack) begin
                    state_d     = FETCH;
                    imem_addr_d = PC_next;
                end else if (redirect) begin
                    // Address is held so the outstanding read finishes untouched.
                    state_d = SQUASH;
                end
            end
            FULL: begin
                if (instr_ready || redirect) begin
                    state_d     = FETCH;
                    imem_addr_d = PC_next;
                end
            end
            SQUASH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d     = FETCH;
                    imem_addr_d = PC_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge PC_rst_n) begin
        if (!PC_rst_n) begin
            state_q      <= IDLE;
            imem_addr_q  <= '0;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            imem_addr_q  <= imem_addr_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

    assign imem_addr   = imem_addr_q;
    assign instr_valid = (state_q == FULL);
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: PC register and wait-state memory models, a table of
// sequential fetches, and hand-written redirect/wrap/reset sequences.
module tb_pc_fetch_seq;
    import pc_fetch_seq_pkg::*;

    localparam logic [WIDTH-1:0] DMASK = 16'hA5A5;

    logic             clk = 1'b0;
    logic             PC_rst_n;
    logic [WIDTH-1:0] PC, PC_next, imem_addr, imem_rdata;
    logic [WIDTH-1:0] instr_data, instr_pc, redirect_pc;
    logic             imem_req, imem_ack, instr_valid, instr_ready, redirect;

    logic [3:0] mem_wait, mem_cnt;

    typedef struct {
        int unsigned      wt;
        int unsigned      hold;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] data;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    vec_t vecs[4];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_fetch_seq dut (
        .clk         (clk),
        .PC_rst_n    (PC_rst_n),
        .PC          (PC),
        .PC_next     (PC_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // PC register: loads PC_next every edge.
    always_ff @(posedge clk or negedge PC_rst_n) begin
        if (!PC_rst_n) PC <= RESET_PC;
        else           PC <= PC_next;
    end

    // Memory: acks after mem_wait stall cycles; data is a fixed function of address.
    assign imem_ack   = imem_req && (mem_cnt == mem_wait);
    assign imem_rdata = imem_addr ^ DMASK;
    always_ff @(posedge clk or negedge PC_rst_n) begin
        if (!PC_rst_n)                  mem_cnt <= '0;
        else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 4'd1;
        else                            mem_cnt <= '0;
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every decode handshake must match the oldest expected fetch.
    always @(negedge clk) begin
        if (PC_rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got delivery pc %h, required none", instr_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_pc", instr_pc, mon_e.pc);
                chk("sb_data", instr_data, mon_e.data);
            end
        end
    end

    // Entered just after the edge into FETCH at address a; leaves just after
    // the edge back into FETCH at a + PC_INC.
    task automatic run_fetch(input int unsigned wt, input int unsigned hold,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] nxt;
        sb_t e;
        nxt = a + PC_INC;
        e.pc = a;
        e.data = d;
        sb.push_back(e);
        mem_wait    = 4'(wt);
        instr_ready = (hold == 0);
        redirect    = 1'b0;
        for (int w = 0; w <= int'(wt); w++) begin
            #1;
            chk("fetch_req", 16'(imem_req), 16'd1);
            chk("fetch_addr", imem_addr, a);
            chk("fetch_no_valid", 16'(instr_valid), 16'd0);
            chk("fetch_pc_next", PC_next, (w == int'(wt)) ? nxt : a);
            tick();
        end
        chk("full_valid", 16'(instr_valid), 16'd1);
        chk("full_pc", instr_pc, a);
        chk("full_data", instr_data, d);
        for (int h = 0; h < int'(hold); h++) begin
            chk("hold_valid", 16'(instr_valid), 16'd1);
            chk("hold_pc", instr_pc, a);
            chk("hold_data", instr_data, d);
            chk("hold_req", 16'(imem_req), 16'd0);
            chk("hold_pc_next", PC_next, nxt);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("full_pc_next", PC_next, nxt);
        tick();
        chk("refetch_req", 16'(imem_req), 16'd1);
        chk("refetch_addr", imem_addr, nxt);
        chk("refetch_no_valid", 16'(instr_valid), 16'd0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 16'h0000, 16'h0000 ^ DMASK};
        vecs[1] = '{0, 0, 16'h0001, 16'h0001 ^ DMASK};
        vecs[2] = '{2, 5, 16'h0002, 16'h0002 ^ DMASK};
        vecs[3] = '{1, 0, 16'h0003, 16'h0003 ^ DMASK};

        PC_rst_n    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        mem_wait    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_next", PC_next, RESET_PC);
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_data", instr_data, 16'h0000);
        chk("rst_ipc", instr_pc, 16'h0000);
        redirect = 1'b0;
        PC_rst_n = 1'b1;
        #1;
        chk("idle_req", 16'(imem_req), 16'd0);
        tick();
        chk("first_req", 16'(imem_req), 16'd1);
        chk("first_addr", imem_addr, RESET_PC);

        for (int i = 0; i < 4; i++)
            run_fetch(vecs[i].wt, vecs[i].hold, vecs[i].addr, vecs[i].data);

        // Redirect coinciding with ack: data dropped, refetch at target.
        mem_wait    = 4'd0;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        chk("rdack_pc_next", PC_next, 16'h0100);
        tick();
        redirect = 1'b0;
        chk("rdack_no_valid", 16'(instr_valid), 16'd0);
        run_fetch(0, 0, 16'h0100, 16'h0100 ^ DMASK);

        // Redirect while waiting for ack; second redirect in SQUASH wins.
        mem_wait    = 4'd3;
        redirect    = 1'b1;
        redirect_pc = 16'h0077;
        #1;
        chk("sq_pc_next0", PC_next, 16'h0077);
        tick();
        redirect_pc = 16'h0040;
        #1;
        chk("sq_pc_next1", PC_next, 16'h0040);
        for (int k = 1; k <= 3; k++) begin
            chk("sq_req", 16'(imem_req), 16'd1);
            chk("sq_addr", imem_addr, 16'h0101);
            chk("sq_no_valid", 16'(instr_valid), 16'd0);
            if (k > 1) chk("sq_pc_hold", PC_next, 16'h0040);
            tick();
            redirect = 1'b0;
            #1;
        end
        run_fetch(0, 0, 16'h0040, 16'h0040 ^ DMASK);

        // Wrap: fetch at FFFF advances to 0000.
        mem_wait    = 4'd0;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        run_fetch(0, 1, 16'hFFFF, 16'hFFFF ^ DMASK);

        // Asynchronous reset in FULL.
        mem_wait    = 4'd0;
        instr_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 16'(instr_valid), 16'd1);
        #2;
        PC_rst_n = 1'b0;
        #1;
        chk("arst_valid", 16'(instr_valid), 16'd0);
        chk("arst_pc_next", PC_next, RESET_PC);
        chk("arst_req", 16'(imem_req), 16'd0);
        chk("arst_data", instr_data, 16'h0000);
        chk("arst_ipc", instr_pc, 16'h0000);
        tick();
        PC_rst_n = 1'b1;
        #1;
        chk("rel_idle_req", 16'(imem_req), 16'd0);
        tick();
        chk("rel_req", 16'(imem_req), 16'd1);
        chk("rel_addr", imem_addr, RESET_PC);
        run_fetch(0, 0, RESET_PC, RESET_PC ^ DMASK);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Fetch sequencer on the consumer side of the PC register.
- Reads the current PC, issues instruction-memory reads at that address, buffers the returned instruction for decode, and computes PC_next for the PC register.
- The PC register loads PC_next on every clk edge, so this block alone decides hold, advance or redirect.

Parameters:
WIDTH, 16, PC / address / instruction width
RESET_PC, 16'h0000, PC_next value while reset is asserted
PC_INC, 1, sequential PC increment per fetched instruction

Ports:
clk  in  1  system clock, rising edge
PC_rst_n  in  1  asynchronous, active-low reset
PC  in  WIDTH  current PC from the PC register
PC_next  out  WIDTH  next PC, combinational, loaded by the PC register every edge
imem_req  out  1  instruction-memory read request
imem_addr  out  WIDTH  read address, registered
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  WIDTH  instruction word
instr_valid  out  1  buffered instruction available to decode
instr_data  out  WIDTH  buffered instruction
instr_pc  out  WIDTH  address the buffered instruction was fetched from
instr_ready  in  1  decode accepts the instruction
redirect  in  1  branch/jump taken, single-cycle pulse
redirect_pc  in  WIDTH  redirect target

Behaviour:
- One clock (clk); reset is asynchronous and active-low (PC_rst_n).
- While PC_rst_n=0: PC_next=RESET_PC, imem_req=0, imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, state=IDLE.
- States: IDLE, FETCH, FULL, SQUASH.
- imem protocol: imem_req held high with a stable imem_addr until imem_ack. The ack cycle completes the transfer. No request is abandoned.
- imem_addr is captured from PC_next on every edge that enters FETCH. It therefore equals the new PC throughout FETCH.
- PC_next is computed each cycle with the following priority:
  - redirect=1: redirect_pc, in any state.
  - FETCH & imem_ack: PC+PC_INC, modulo 2^WIDTH (16'hFFFF+1 -> 16'h0000).
  - Otherwise: PC (hold).
- IDLE: entered only from reset. Goes to FETCH on the next edge.
- FETCH: imem_req=1.
  - imem_ack & !redirect: latch imem_rdata->instr_data and imem_addr->instr_pc; instr_valid=1 next cycle; go to FULL.
  - imem_ack & redirect: discard data; go to FETCH with the new address. imem_req stays high.
  - !imem_ack & redirect: go to SQUASH. imem_addr is held, so the outstanding request completes unchanged.
- FULL: instr_valid=1, imem_req=0.
  - instr_ready=1: the handshake counts as delivered; instr_valid=0 next cycle; go to FETCH.
  - redirect, with or without instr_ready: instr_valid=0 next cycle; go to FETCH. If ready was also high, the instruction counts as consumed.
  - !instr_ready & !redirect: hold all outputs stable.
- SQUASH: imem_req=1 at the old imem_addr.
  - On imem_ack: discard data; go to FETCH (imem_addr captures PC_next).
  - A further redirect in SQUASH updates PC_next; the last target wins.
- Latency:
  - Reset release -> first imem_req: 1 cycle.
  - imem_ack -> instr_valid: 1 cycle.
  - ready -> next imem_req: 1 cycle.
  - Peak throughput: 1 instruction per 2 cycles with zero-wait memory.
- instr_valid is never high in FETCH, SQUASH or IDLE. A squashed fetch never reaches instr_valid.
- Reset asserted mid-operation clears everything immediately (asynchronously). Any in-flight imem transfer is abandoned. The memory model must also reset.

Decomposition:
- Shared package: state enum (IDLE/FETCH/FULL/SQUASH, 2 bits), WIDTH, RESET_PC, PC_INC. The same package is used by the PC register and decode.
- One natural sub-module, pc_next_mux: combinational priority select of redirect_pc / PC+PC_INC / PC, including the wrap.
- FSM and output buffer stay in pc_fetch_seq.

Test Plan:
- Reset, then release with zero-wait memory and ready=1 -> imem_addr sequence 0000, 0001, 0002; instr_pc matches each; PC_next=0000 during reset.
- PC=FFFF, ack in FETCH -> PC_next=0000; instr_pc=FFFF.
- instr_ready=0 for 5 cycles in FULL -> instr_valid, instr_data, instr_pc stable; imem_req=0; PC held.
- Redirect to 0040 while FETCH waits 3 cycles for ack -> imem_addr stays old until ack; data dropped; next request at 0040; instr_valid never asserted for the old address.
- Redirect to 0100 together with imem_ack in FETCH -> no instr_valid; next cycle imem_req=1, imem_addr=0100.
- PC_rst_n pulled low mid-FULL -> instr_valid=0 and PC_next=RESET_PC within the same cycle, with no clk edge; fetch restarts at 0000 after release.
